// File: rtl/inst_fetch.sv
// Gumnut instruction fetch: program counter, return-address stack and the
// instruction-bus master. Define INST_FETCH_STACK_CHECK_EN for stack overflow/underflow detection.
module inst_fetch #(
  parameter logic [11:0] RESET_PC    = 12'h000,
  parameter int          STACK_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic        fetch_i,
  input  logic        pc_upd_i,
  input  logic [1:0]  pc_sel_i,
  input  logic [11:0] pc_target_i,
  output logic        inst_cyc_o,
  output logic        inst_stb_o,
  output logic [11:0] inst_adr_o,
  input  logic        inst_ack_i,
  input  logic [17:0] inst_dat_i,
  output logic [17:0] inst_o,
  output logic        ack_o,
  output logic [11:0] pc_o,
  output logic        busy_o,
  output logic        stk_ovf_o,
  output logic        stk_unf_o
);

  localparam int SP_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [1:0] SEL_INC    = 2'b00;
  localparam logic [1:0] SEL_LOAD   = 2'b01;
  localparam logic [1:0] SEL_CALL   = 2'b10;
  localparam logic [1:0] SEL_RETURN = 2'b11;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } state_t;

  state_t            r_state;
  logic              r_cyc;
  logic [11:0]       r_pc;
  logic [SP_W-1:0]   r_sp;
  logic [11:0]       r_stack [STACK_DEPTH];

  logic              w_upd;
  logic              w_push;
  logic              w_pop;
  logic [11:0]       w_pc_inc;
  logic [11:0]       w_pc_next;
  logic [SP_W-1:0]   w_sp_dec;

  // Bus handshake: cyc and stb rise together for a whole access and stay
  // high until the memory raises ack; the access completes in the cycle
  // where ack is seen while cyc is high, and the word is valid that cycle.
  assign inst_cyc_o = r_cyc;
  assign inst_stb_o = r_cyc;
  assign inst_adr_o = r_pc;
  assign inst_o     = inst_dat_i;
  assign ack_o      = inst_ack_i & (r_state == S_FETCH) & cen & ~rst;
  assign pc_o       = r_pc;
  assign busy_o     = (r_state == S_FETCH);

  assign w_upd    = cen & ~rst & pc_upd_i & (r_state == S_IDLE);
  assign w_pc_inc = r_pc + 12'd1;
  assign w_sp_dec = r_sp - SP_W'(1);

`ifdef INST_FETCH_STACK_CHECK_EN
  logic [SP_W:0] r_cnt;
  logic          r_ovf;
  logic          r_unf;
  logic          w_full;
  logic          w_empty;

  assign w_full    = (r_cnt == (SP_W+1)'(STACK_DEPTH));
  assign w_empty   = (r_cnt == '0);
  assign w_push    = w_upd & (pc_sel_i == SEL_CALL) & ~w_full;
  assign w_pop     = w_upd & (pc_sel_i == SEL_RETURN) & ~w_empty;
  assign stk_ovf_o = r_ovf;
  assign stk_unf_o = r_unf;

  // Occupancy and sticky error flags; only reset clears the flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_push) r_cnt <= r_cnt + (SP_W+1)'(1);
      if (w_pop)  r_cnt <= r_cnt - (SP_W+1)'(1);
      if (w_upd && pc_sel_i == SEL_CALL && w_full)    r_ovf <= 1'b1;
      if (w_upd && pc_sel_i == SEL_RETURN && w_empty) r_unf <= 1'b1;
    end
  end
`else
  assign w_push    = w_upd & (pc_sel_i == SEL_CALL);
  assign w_pop     = w_upd & (pc_sel_i == SEL_RETURN);
  assign stk_ovf_o = 1'b0;
  assign stk_unf_o = 1'b0;
`endif

  // A return on an empty checked stack falls through to PC+1.
  always_comb begin
    w_pc_next = w_pc_inc;
    case (pc_sel_i)
      SEL_INC:    w_pc_next = w_pc_inc;
      SEL_LOAD:   w_pc_next = pc_target_i;
      SEL_CALL:   w_pc_next = pc_target_i;
      SEL_RETURN: w_pc_next = w_pop ? r_stack[w_sp_dec] : w_pc_inc;
      default:    w_pc_next = w_pc_inc;
    endcase
  end

  // Stack storage carries no reset; only the pointer is initialised.
  always_ff @(posedge clk) begin
    if (w_push) r_stack[r_sp] <= w_pc_inc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cyc   <= 1'b0;
      r_pc    <= RESET_PC;
      r_sp    <= '0;
    end else if (cen) begin
      case (r_state)
        S_IDLE: begin
          if (pc_upd_i) r_pc <= w_pc_next;
          if (w_push)   r_sp <= r_sp + SP_W'(1);
          if (w_pop)    r_sp <= w_sp_dec;
          if (fetch_i) begin
            r_state <= S_FETCH;
            r_cyc   <= 1'b1;
          end
        end
        S_FETCH: begin
          if (inst_ack_i) begin
            r_state <= S_IDLE;
            r_cyc   <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cyc   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: stimulus pushes expected deliveries and
// probes into queues, and a negedge monitor checks them against the DUT.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic        fetch_i;
  logic        pc_upd_i;
  logic [1:0]  pc_sel_i;
  logic [11:0] pc_target_i;
  logic        inst_cyc_o;
  logic        inst_stb_o;
  logic [11:0] inst_adr_o;
  logic        inst_ack_i;
  logic [17:0] inst_dat_i;
  logic [17:0] inst_o;
  logic        ack_o;
  logic [11:0] pc_o;
  logic        busy_o;
  logic        stk_ovf_o;
  logic        stk_unf_o;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk(clk), .rst(rst), .cen(cen), .fetch_i(fetch_i),
    .pc_upd_i(pc_upd_i), .pc_sel_i(pc_sel_i), .pc_target_i(pc_target_i),
    .inst_cyc_o(inst_cyc_o), .inst_stb_o(inst_stb_o), .inst_adr_o(inst_adr_o),
    .inst_ack_i(inst_ack_i), .inst_dat_i(inst_dat_i), .inst_o(inst_o),
    .ack_o(ack_o), .pc_o(pc_o), .busy_o(busy_o),
    .stk_ovf_o(stk_ovf_o), .stk_unf_o(stk_unf_o)
  );

  localparam int W = 30;
  localparam int K_PC = 0, K_CYC = 1, K_STB = 2, K_ACK = 3, K_BUSY = 4,
                 K_ADR = 5, K_OVF = 6, K_UNF = 7, K_QLEN = 8;

  typedef struct {
    int          kind;
    logic [31:0] val;
  } probe_t;

  logic [W-1:0] exp_q[$];
  probe_t       probe_q[$];
  int           n_tests = 0;
  int           n_fail  = 0;

`ifdef INST_FETCH_STACK_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  function automatic logic [31:0] actual(input int kind);
    case (kind)
      K_PC:    return {20'd0, pc_o};
      K_CYC:   return {31'd0, inst_cyc_o};
      K_STB:   return {31'd0, inst_stb_o};
      K_ACK:   return {31'd0, ack_o};
      K_BUSY:  return {31'd0, busy_o};
      K_ADR:   return {20'd0, inst_adr_o};
      K_OVF:   return {31'd0, stk_ovf_o};
      K_UNF:   return {31'd0, stk_unf_o};
      K_QLEN:  return 32'(exp_q.size());
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic string kname(input int kind);
    case (kind)
      K_PC:    return "pc_o";
      K_CYC:   return "inst_cyc_o";
      K_STB:   return "inst_stb_o";
      K_ACK:   return "ack_o";
      K_BUSY:  return "busy_o";
      K_ADR:   return "inst_adr_o";
      K_OVF:   return "stk_ovf_o";
      K_UNF:   return "stk_unf_o";
      K_QLEN:  return "pending_deliveries";
      default: return "unknown";
    endcase
  endfunction

  // Monitor: every delivered word is matched against the scoreboard, then
  // any probes queued for this cycle are evaluated.
  always @(negedge clk) begin
    probe_t       p;
    logic [W-1:0] e;
    logic [31:0]  a;
    if (ack_o) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL delivery t=%0t got adr=%h inst=%h, required no delivery", $time, inst_adr_o, inst_o);
      end else begin
        e = exp_q.pop_front();
        if ({inst_adr_o, inst_o} !== e) begin
          n_fail++;
          $display("FAIL delivery t=%0t got adr=%h inst=%h, required adr=%h inst=%h",
                   $time, inst_adr_o, inst_o, e[29:18], e[17:0]);
        end
      end
    end
    while (probe_q.size() > 0) begin
      p = probe_q.pop_front();
      a = actual(p.kind);
      n_tests++;
      if (a !== p.val) begin
        n_fail++;
        $display("FAIL %s t=%0t got %h, required %h", kname(p.kind), $time, a, p.val);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(input int kind, input logic [31:0] val);
    probe_t p;
    p.kind = kind;
    p.val  = val;
    probe_q.push_back(p);
  endtask

  task automatic upd(input logic [1:0] sel, input logic [11:0] tgt);
    pc_upd_i    = 1'b1;
    pc_sel_i    = sel;
    pc_target_i = tgt;
    step();
    pc_upd_i    = 1'b0;
  endtask

  // One bus access with optional same-cycle PC update and optional
  // (ignored) PC load attempts during wait states.
  task automatic fetch(input logic [11:0] adr, input logic [17:0] dat, input int waits,
                       input logic pre_upd, input logic [11:0] pre_tgt, input logic mid_upd);
    fetch_i     = 1'b1;
    pc_upd_i    = pre_upd;
    pc_sel_i    = 2'b01;
    pc_target_i = pre_tgt;
    exp_q.push_back({adr, dat});
    step();
    fetch_i  = 1'b0;
    pc_upd_i = 1'b0;
    for (int i = 0; i < waits; i++) begin
      inst_ack_i = 1'b0;
      inst_dat_i = 18'($urandom);
      pc_upd_i    = mid_upd;
      pc_sel_i    = 2'b01;
      pc_target_i = 12'h555;
      probe(K_CYC, 1);
      probe(K_STB, 1);
      probe(K_ACK, 0);
      probe(K_ADR, {20'd0, adr});
      step();
      pc_upd_i = 1'b0;
    end
    inst_ack_i = 1'b1;
    inst_dat_i = dat;
    probe(K_ACK, 1);
    probe(K_CYC, 1);
    step();
    inst_ack_i = 1'b0;
    inst_dat_i = 18'($urandom);
    probe(K_ACK, 0);
    probe(K_CYC, 0);
    probe(K_BUSY, 0);
  endtask

  logic [11:0] ret_exp [10];
  logic [11:0] tgt;

  initial begin
    if (CHK) begin
      ret_exp = '{12'hA07, 12'hA06, 12'hA05, 12'hA04, 12'hA03,
                  12'hA02, 12'hA01, 12'h012, 12'h013, 12'h014};
    end else begin
      ret_exp = '{12'hA08, 12'hA07, 12'hA06, 12'hA05, 12'hA04,
                  12'hA03, 12'hA02, 12'hA01, 12'hA08, 12'hA07};
    end
    rst = 1'b1; cen = 1'b1; fetch_i = 1'b0; pc_upd_i = 1'b0;
    pc_sel_i = 2'b00; pc_target_i = 12'h000; inst_ack_i = 1'b0; inst_dat_i = 18'h0;
    step();
    rst = 1'b0;
    probe(K_PC, 0); probe(K_CYC, 0); probe(K_STB, 0); probe(K_ACK, 0);
    probe(K_BUSY, 0); probe(K_ADR, 0); probe(K_OVF, 0); probe(K_UNF, 0);
    step();

    // Reset then zero-wait fetch
    fetch(12'h000, 18'h2A5A5, 0, 1'b0, 12'h000, 1'b0);
    step();
    // Three wait states; PC loads during FETCH must be ignored
    fetch(12'h000, 18'h12345, 3, 1'b0, 12'h000, 1'b1);
    probe(K_PC, 12'h000);
    step();

    // Sequential wrap, then load + fetch in the same cycle
    upd(2'b01, 12'hFFE); probe(K_PC, 12'hFFE);
    upd(2'b00, 12'h000); probe(K_PC, 12'hFFF);
    upd(2'b00, 12'h000); probe(K_PC, 12'h000);
    fetch(12'h3C0, 18'h3F00F, 1, 1'b1, 12'h3C0, 1'b0);
    probe(K_PC, 12'h3C0);
    step();

    // Eight nested calls then eight returns
    upd(2'b01, 12'h010); probe(K_PC, 12'h010);
    for (int i = 0; i < 8; i++) begin
      tgt = 12'((i + 1) * 256);
      upd(2'b10, tgt);
      probe(K_PC, {20'd0, tgt});
      probe(K_OVF, 0);
    end
    for (int k = 7; k >= 0; k--) begin
      upd(2'b11, 12'h000);
      probe(K_PC, (k == 0) ? 32'h011 : 32'(k * 256 + 1));
      probe(K_UNF, 0);
    end

    // Call at the top of the address space pushes 0
    upd(2'b01, 12'hFFF);
    upd(2'b10, 12'h123); probe(K_PC, 12'h123);
    upd(2'b11, 12'h000); probe(K_PC, 12'h000);

    // Ninth call and returns past the bottom of the stack
    upd(2'b01, 12'h011);
    for (int j = 0; j < 9; j++) upd(2'b10, 12'(12'hA00 + j));
    probe(K_PC, 12'hA08);
    probe(K_OVF, {31'd0, CHK});
    for (int r = 0; r < 10; r++) begin
      upd(2'b11, 12'h000);
      probe(K_PC, {20'd0, ret_exp[r]});
      if (r == 7) probe(K_UNF, 0);
    end
    probe(K_UNF, {31'd0, CHK});
    step();

    // Reset in the same cycle as ack: nothing delivered
    fetch_i = 1'b1;
    step();
    fetch_i = 1'b0;
    probe(K_CYC, 1);
    inst_ack_i = 1'b1; inst_dat_i = 18'h3FFFF; rst = 1'b1;
    probe(K_ACK, 0);
    step();
    inst_ack_i = 1'b0; rst = 1'b0;
    probe(K_CYC, 0); probe(K_PC, 0); probe(K_BUSY, 0);
    probe(K_ADR, 0); probe(K_OVF, 0); probe(K_UNF, 0);
    step();

    // Clock-enable low holds PC, state and bus
    upd(2'b01, 12'h055);
    cen = 1'b0; fetch_i = 1'b1; pc_upd_i = 1'b1; pc_sel_i = 2'b01; pc_target_i = 12'h777;
    step(); step();
    probe(K_PC, 12'h055); probe(K_BUSY, 0); probe(K_CYC, 0);
    pc_upd_i = 1'b0; cen = 1'b1;
    exp_q.push_back({12'h055, 18'h0BEEF});
    step();
    fetch_i = 1'b0; cen = 1'b0; inst_ack_i = 1'b1; inst_dat_i = 18'h0BEEF;
    probe(K_ACK, 0); probe(K_CYC, 1);
    step();
    probe(K_CYC, 1); probe(K_BUSY, 1); probe(K_ACK, 0);
    step();
    cen = 1'b1;
    probe(K_ACK, 1);
    step();
    inst_ack_i = 1'b0;
    probe(K_CYC, 0); probe(K_PC, 12'h055);
    step();

    probe(K_QLEN, 0);
    step();
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
